// File: rtl/updown_pkg.sv
// Shared encodings for the up/down count-stream decoder: FSM states, step codes
// and a saturating increment used by the legal-run counter.
package updown_pkg;

   typedef logic [1:0] state_t;
   typedef logic [1:0] step_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_SYNC = 2'd1;
   localparam state_t ST_LOCK = 2'd2;

   localparam step_t STEP_HOLD = 2'd0;
   localparam step_t STEP_UP   = 2'd1;
   localparam step_t STEP_DOWN = 2'd2;
   localparam step_t STEP_ILL  = 2'd3;

   localparam int RUNW = 8;

   function automatic logic is_move(input step_t step);
      return (step == STEP_UP) || (step == STEP_DOWN);
   endfunction

   function automatic logic [RUNW-1:0] run_sat_inc(input logic [RUNW-1:0] run);
      return (run == {RUNW{1'b1}}) ? run : run + {{(RUNW-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/updown_step_cls.sv
// Classifies one transition of the observed count: hold, +1, -1 (modulo 2^W,
// so wrap-around is a legal step) or an illegal jump.
module updown_step_cls
   import updown_pkg::*;
#(
   parameter int W = 3
)
(
   input  logic [W-1:0] q_prev,
   input  logic [W-1:0] q_in,
   output step_t        step
);

   logic [W-1:0] q_inc;
   logic [W-1:0] q_dec;

   assign q_inc = q_prev + {{(W-1){1'b0}}, 1'b1};
   assign q_dec = q_prev - {{(W-1){1'b0}}, 1'b1};

   // Priority is irrelevant for W>=2 since the three targets are distinct
   always_comb begin
      step = STEP_ILL;
      if (q_in == q_prev) begin
         step = STEP_HOLD;
      end else if (q_in == q_inc) begin
         step = STEP_UP;
      end else if (q_in == q_dec) begin
         step = STEP_DOWN;
      end else begin
         step = STEP_ILL;
      end
   end

endmodule

// File: rtl/updown_decoder.sv
// Receive-side decoder for an up/down count bus: recovers enable/direction,
// flags illegal jumps and reports lock after a run of legal moving steps.
module updown_decoder
   import updown_pkg::*;
#(
   parameter int W        = 3,
   parameter int LOCK_CNT = 4,
   parameter int ERRW     = 8
)
(
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   input  logic [W-1:0]    q_in,
   output logic            t_out,
   output logic            c_out,
   output logic            locked,
   output logic            err,
   output logic [ERRW-1:0] err_count
);

   localparam logic [RUNW-1:0] LOCK_RUN = LOCK_CNT[RUNW-1:0];
   localparam logic [ERRW-1:0] ERR_ONE  = {{(ERRW-1){1'b0}}, 1'b1};
   localparam logic [ERRW-1:0] ERR_MAX  = {ERRW{1'b1}};

   state_t          state_r;
   state_t          state_nxt;
   logic [W-1:0]    q_prev_r;
   logic [W-1:0]    q_prev_nxt;
   logic [RUNW-1:0] run_r;
   logic [RUNW-1:0] run_nxt;
   logic [RUNW-1:0] run_inc;
   logic            t_nxt;
   logic            c_nxt;
   logic            locked_nxt;
   logic            err_nxt;
   logic [ERRW-1:0] err_count_nxt;
   logic [ERRW-1:0] err_count_inc;
   step_t           step;

   updown_step_cls #(.W(W)) u_step_cls (
      .q_prev (q_prev_r),
      .q_in   (q_in),
      .step   (step)
   );

   assign run_inc       = run_sat_inc(run_r);
   assign err_count_inc = (err_count == ERR_MAX) ? err_count : err_count + ERR_ONE;

   // Next-state logic; err defaults low so every pulse lasts exactly one sample
   always_comb begin
      state_nxt     = state_r;
      q_prev_nxt    = q_prev_r;
      run_nxt       = run_r;
      t_nxt         = t_out;
      c_nxt         = c_out;
      locked_nxt    = locked;
      err_nxt       = 1'b0;
      err_count_nxt = err_count;
      if (en) begin
         // Always resync to the observed value, even after an illegal jump
         q_prev_nxt = q_in;
         case (state_r)
            ST_IDLE: begin
               t_nxt      = 1'b0;
               run_nxt    = {RUNW{1'b0}};
               locked_nxt = 1'b0;
               state_nxt  = ST_SYNC;
            end
            ST_SYNC, ST_LOCK: begin
               if (is_move(step)) begin
                  t_nxt   = 1'b1;
                  c_nxt   = (step == STEP_UP);
                  run_nxt = run_inc;
                  if ((state_r == ST_SYNC) && (run_inc == LOCK_RUN)) begin
                     state_nxt  = ST_LOCK;
                     locked_nxt = 1'b1;
                  end else begin
                     state_nxt  = state_r;
                  end
               end else if (step == STEP_HOLD) begin
                  t_nxt = 1'b0;
               end else begin
                  t_nxt         = 1'b0;
                  err_nxt       = 1'b1;
                  err_count_nxt = err_count_inc;
                  run_nxt       = {RUNW{1'b0}};
                  locked_nxt    = 1'b0;
                  state_nxt     = ST_SYNC;
               end
            end
            default: begin
               t_nxt      = 1'b0;
               run_nxt    = {RUNW{1'b0}};
               locked_nxt = 1'b0;
               state_nxt  = ST_IDLE;
            end
         endcase
      end else begin
         state_nxt = state_r;
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         q_prev_r  <= {W{1'b0}};
         run_r     <= {RUNW{1'b0}};
         t_out     <= 1'b0;
         c_out     <= 1'b0;
         locked    <= 1'b0;
         err       <= 1'b0;
         err_count <= {ERRW{1'b0}};
      end else begin
         state_r   <= state_nxt;
         q_prev_r  <= q_prev_nxt;
         run_r     <= run_nxt;
         t_out     <= t_nxt;
         c_out     <= c_nxt;
         locked    <= locked_nxt;
         err       <= err_nxt;
         err_count <= err_count_nxt;
      end
   end

endmodule

// File: tb/tb_updown_decoder.sv
// Self-checking bench for updown_decoder: directed scenarios plus randomized
// streams compared against a modular-arithmetic reference model.
module tb_updown_decoder;

   localparam int W        = 3;
   localparam int MOD      = 8;
   localparam int LOCK_CNT = 4;
   localparam int ERRW     = 8;
   localparam int ERR_MAX  = 255;

   logic            clk;
   logic            reset;
   logic            en;
   logic [W-1:0]    q_in;
   logic            t_out;
   logic            c_out;
   logic            locked;
   logic            err;
   logic [ERRW-1:0] err_count;

   int n_checks;
   int n_pass;

   // Reference model state
   bit m_started;
   bit m_t;
   bit m_c;
   bit m_locked;
   bit m_err;
   int m_cnt;
   int m_run;
   int m_prev;

   updown_decoder #(.W(W), .LOCK_CNT(LOCK_CNT), .ERRW(ERRW)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .q_in      (q_in),
      .t_out     (t_out),
      .c_out     (c_out),
      .locked    (locked),
      .err       (err),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_started = 1'b0;
      m_t = 1'b0; m_c = 1'b0; m_locked = 1'b0; m_err = 1'b0;
      m_cnt = 0; m_run = 0; m_prev = 0;
   endtask

   task automatic model_step(input bit e, input int q);
      int d;
      if (!e) begin
         m_err = 1'b0;
         return;
      end
      if (!m_started) begin
         m_started = 1'b1;
         m_t = 1'b0;
         m_err = 1'b0;
      end else begin
         d = (q - m_prev + MOD) % MOD;
         if (d == 0) begin
            m_t = 1'b0; m_err = 1'b0;
         end else if (d == 1 || d == MOD - 1) begin
            m_t = 1'b1; m_c = (d == 1); m_err = 1'b0;
            m_run++;
            if (m_run >= LOCK_CNT) m_locked = 1'b1;
         end else begin
            m_t = 1'b0; m_err = 1'b1; m_run = 0; m_locked = 1'b0;
            m_cnt = (m_cnt < ERR_MAX) ? m_cnt + 1 : ERR_MAX;
         end
      end
      m_prev = q;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".t_out"},     32'(t_out),     32'(m_t));
      check({tag, ".c_out"},     32'(c_out),     32'(m_c));
      check({tag, ".locked"},    32'(locked),    32'(m_locked));
      check({tag, ".err"},       32'(err),       32'(m_err));
      check({tag, ".err_count"}, 32'(err_count), 32'(m_cnt));
   endtask

   // Called at a negedge: apply inputs, let one posedge sample them, check at next negedge
   task automatic drive(input string tag, input bit e, input int q);
      en   = e;
      q_in = W'(q);
      @(posedge clk);
      model_step(e, q);
      @(negedge clk);
      check_all(tag);
   endtask

   initial begin
      int q;
      int kind;
      bit e;
      n_checks = 0;
      n_pass   = 0;
      model_reset();
      reset = 1'b1;
      en    = 1'b0;
      q_in  = 3'd0;
      repeat (2) @(negedge clk);
      check_all("reset");
      reset = 1'b0;

      // 1: hold 5 after reset
      for (int i = 0; i < 3; i++) drive("hold5", 1'b1, 5);
      // 2: 5->0 jump, then climb to lock
      for (int i = 0; i <= 4; i++) drive("climb", 1'b1, i);
      check("climb.locked_final", 32'(locked), 32'd1);
      // 3: wrap both ways while locked
      drive("wrap", 1'b1, 5);
      drive("wrap", 1'b1, 6);
      drive("wrap", 1'b1, 7);
      drive("wrap_up", 1'b1, 0);
      check("wrap_up.c_out", 32'(c_out), 32'd1);
      drive("wrap_dn", 1'b1, 7);
      check("wrap_dn.c_out", 32'(c_out), 32'd0);
      drive("wrap", 1'b1, 6);
      // 4: walk down to 3, illegal jump to 6, relock via 7,0,1,2
      for (int i = 5; i >= 3; i--) drive("down", 1'b1, i);
      drive("ill", 1'b1, 6);
      check("ill.err", 32'(err), 32'd1);
      drive("relock", 1'b1, 7);
      check("ill.err_pulse", 32'(err), 32'd0);
      drive("relock", 1'b1, 0);
      drive("relock", 1'b1, 1);
      drive("relock", 1'b1, 2);
      // 5: freeze while q jumps, then resume at the held value
      drive("frz", 1'b0, 5);
      drive("frz", 1'b0, 5);
      drive("unfrz", 1'b1, 2);
      drive("unfrz", 1'b1, 3);
      // illegal followed by freeze clears err but holds everything else
      drive("ill2", 1'b1, 7);
      drive("frz_err", 1'b0, 1);
      // async reset mid-stream with no clock edge in between
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      reset = 1'b0;
      drive("post_rst", 1'b1, 6);
      drive("post_rst", 1'b1, 2);

      // randomized stream
      for (int i = 0; i < 400; i++) begin
         e    = ($urandom_range(0, 9) != 0);
         kind = $urandom_range(0, 4);
         case (kind)
            0:       q = m_prev;
            1, 2:    q = (m_prev + 1) % MOD;
            3:       q = (m_prev + MOD - 1) % MOD;
            default: q = $urandom_range(0, MOD - 1);
         endcase
         drive("rand", e, q);
      end

      // 6: saturate the error counter with back-to-back illegal jumps
      for (int i = 0; i < 260; i++) drive("sat", 1'b1, (m_prev + 4) % MOD);
      check("sat.final", 32'(err_count), 32'(ERR_MAX));
      check("sat.err", 32'(err), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
